seq_arith_unit: RTL and testbench



---
 rtl/seq_arith_unit_pkg.sv | 17 +
 rtl/seq_arith_unit_if.sv | 32 +++
 rtl/seq_arith_unit_step.sv | 45 ++++
 rtl/seq_arith_unit.sv | 131 +++++++++++++
 tb/tb_seq_arith_unit.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_arith_unit_pkg.sv
// arith_pkg
// Shared definitions for seq_arith_unit: the 2-bit operation encoding seen on
// the op input, and the controller state type used by the top-level FSM.
package arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_arith_unit_if.sv
// seq_arith_unit_if
// Request/response bundle between the operand registers and seq_arith_unit.
//   start  : request, taken only while the unit is not busy
//   op     : operation select (see arith_pkg)
//   a, b   : W-bit unsigned operands, captured together with start
//   busy   : a multi-cycle operation is running, start is ignored
//   done   : one-cycle pulse, result/flag just updated
//   result : 2W-bit registered result, holds until the next done
//   flag   : carry / borrow / high-half-nonzero / divide-by-zero
// master drives the request, slave is the arithmetic unit.
interface seq_arith_unit_if #(parameter int W = 8);

    logic             start;
    logic [1:0]       op;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   result;
    logic             flag;

    modport master (
        output start, op, a, b,
        input  busy, done, result, flag
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, flag
    );

endinterface

// File: rtl/seq_arith_unit_step.sv
// arith_iter_step
// One combinational iteration of the sequential multiply / divide.
//   is_div  : 1 = restoring-division step, 0 = shift-add multiply step
//   acc_in  : 2W+1 bit accumulator {upper W+1 bits, lower W bits}
//   operand : multiplicand (mul) or divisor (div)
//   acc_out : accumulator after this iteration
// Multiply: lower half holds the remaining multiplier bits; the upper half
// collects partial products and the whole word shifts right each step.
// Divide: upper half is the running remainder, lower half shifts the dividend
// out and the quotient bits in from the right.
module arith_iter_step #(
    parameter int W = 8
) (
    input  logic           is_div,
    input  logic [2*W:0]   acc_in,
    input  logic [W-1:0]   operand,
    output logic [2*W:0]   acc_out
);

    logic [W:0]   upper_sum;
    logic [2*W:0] shifted;
    logic [W:0]   trial;

    // The remainder never reaches the divisor, so it fits in W bits and the
    // left shift cannot lose a significant bit out of the top of acc.
    always_comb begin
        acc_out   = acc_in;
        upper_sum = '0;
        shifted   = '0;
        trial     = '0;
        if (is_div) begin
            shifted = acc_in << 1;
            trial   = shifted[2*W:W] - {1'b0, operand};
            if (shifted[2*W:W] >= {1'b0, operand}) begin
                acc_out = {trial, shifted[W-1:1], 1'b1};
            end else begin
                acc_out = shifted;
            end
        end else begin
            upper_sum = acc_in[2*W:W] + (acc_in[0] ? {1'b0, operand} : {(W+1){1'b0}});
            acc_out   = {1'b0, upper_sum, acc_in[W-1:1]};
        end
    end

endmodule

// File: rtl/seq_arith_unit.sv
// seq_arith_unit
// Multi-cycle unsigned arithmetic unit with a start/busy/done handshake.
// add/sub and divide-by-zero finish at the accepting edge; mul/div run W
// iterations of arith_iter_step before the result is registered.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset, aborts any running operation
//   bus : seq_arith_unit_if slave (start/op/a/b in, busy/done/result/flag out)
module seq_arith_unit
    import arith_pkg::*;
#(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst,
    seq_arith_unit_if.slave bus
);

    localparam int CW = $clog2(W);

    state_t            state;
    logic [CW-1:0]     count;
    logic [1:0]        op_q;
    logic [W-1:0]      operand_q;
    logic [2*W:0]      acc;
    logic [2*W:0]      acc_next;
    logic              is_div;

    logic              busy_q;
    logic              done_q;
    logic [2*W-1:0]    result_q;
    logic              flag_q;

    logic [W:0]        sum;
    logic [W:0]        diff;

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.flag   = flag_q;

    // Single-cycle operations are evaluated straight off the request inputs
    // so their result can be registered at the accepting edge; the top bit
    // of diff is the borrow.
    assign sum    = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff   = {1'b0, bus.a} - {1'b0, bus.b};
    assign is_div = (op_q == OP_DIV);

    arith_iter_step #(.W(W)) u_step (
        .is_div  (is_div),
        .acc_in  (acc),
        .operand (operand_q),
        .acc_out (acc_next)
    );

    // Controller. DONE behaves like IDLE for accepting a new request, which
    // gives back-to-back operation when start is held. In CALC the counter
    // runs W-1 down to 0, one iteration per edge, and the last iteration's
    // output is registered straight into result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            op_q      <= OP_ADD;
            operand_q <= '0;
            acc       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            flag_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                CALC: begin
                    acc <= acc_next;
                    if (count == '0) begin
                        state    <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= acc_next[2*W-1:0];
                        flag_q   <= (op_q == OP_MUL) ? (|acc_next[2*W-1:W]) : 1'b0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        op_q <= bus.op;
                        case (bus.op)
                            OP_ADD: begin
                                state    <= DONE;
                                done_q   <= 1'b1;
                                result_q <= {{(W-1){1'b0}}, sum};
                                flag_q   <= sum[W];
                            end
                            OP_SUB: begin
                                state    <= DONE;
                                done_q   <= 1'b1;
                                result_q <= {{W{1'b0}}, diff[W-1:0]};
                                flag_q   <= diff[W];
                            end
                            OP_MUL: begin
                                state     <= CALC;
                                busy_q    <= 1'b1;
                                count     <= CW'(W-1);
                                operand_q <= bus.a;
                                acc       <= {{(W+1){1'b0}}, bus.b};
                            end
                            OP_DIV: begin
                                if (bus.b == '0) begin
                                    state    <= DONE;
                                    done_q   <= 1'b1;
                                    result_q <= {bus.a, {W{1'b1}}};
                                    flag_q   <= 1'b1;
                                end else begin
                                    state     <= CALC;
                                    busy_q    <= 1'b1;
                                    count     <= CW'(W-1);
                                    operand_q <= bus.b;
                                    acc       <= {{(W+1){1'b0}}, bus.a};
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_arith_unit.sv
// tb_seq_arith_unit
// Self-checking bench for seq_arith_unit. Two instances (W=8 and W=4) share
// clock and reset; a selector routes the request to one of them and muxes
// its outputs back. Expected values come from plain integer arithmetic.
module tb_seq_arith_unit;
    import arith_pkg::*;

    logic clk;
    logic rst;

    seq_arith_unit_if #(.W(8)) bus8 ();
    seq_arith_unit_if #(.W(4)) bus4 ();

    seq_arith_unit #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    seq_arith_unit #(.W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    logic        sel4;
    logic        drv_start;
    logic [1:0]  drv_op;
    logic [7:0]  drv_a;
    logic [7:0]  drv_b;

    logic        obs_busy;
    logic        obs_done;
    logic [15:0] obs_result;
    logic        obs_flag;

    int checks;
    int failures;

    assign bus8.start = sel4 ? 1'b0 : drv_start;
    assign bus8.op    = drv_op;
    assign bus8.a     = drv_a;
    assign bus8.b     = drv_b;
    assign bus4.start = sel4 ? drv_start : 1'b0;
    assign bus4.op    = drv_op;
    assign bus4.a     = drv_a[3:0];
    assign bus4.b     = drv_b[3:0];

    assign obs_busy   = sel4 ? bus4.busy : bus8.busy;
    assign obs_done   = sel4 ? bus4.done : bus8.done;
    assign obs_result = sel4 ? {8'h00, bus4.result} : bus8.result;
    assign obs_flag   = sel4 ? bus4.flag : bus8.flag;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: result/flag from integer arithmetic, plus the
    // number of sampled cycles to done and how many of them show busy.
    function automatic void refModel(input int w, input logic [1:0] op, input int a, input int b,
                                     output int res, output int flg, output int lat, output int bsy);
        int m;
        m   = 1 << w;
        lat = 1;
        bsy = 0;
        case (op)
            OP_ADD: begin
                res = a + b;
                flg = (a + b >= m) ? 1 : 0;
            end
            OP_SUB: begin
                res = (a - b + m) % m;
                flg = (a < b) ? 1 : 0;
            end
            OP_MUL: begin
                res = a * b;
                flg = (res >= m) ? 1 : 0;
                lat = w + 1;
                bsy = w;
            end
            default: begin
                if (b == 0) begin
                    res = a * m + (m - 1);
                    flg = 1;
                end else begin
                    res = (a % b) * m + (a / b);
                    flg = 0;
                    lat = w + 1;
                    bsy = w;
                end
            end
        endcase
    endfunction

    // Issue one request and follow it to done. Operand inputs are scrambled
    // right after acceptance; with glitch set, a stray start is also pulsed
    // while the unit is busy.
    task automatic applyStimulus(input int w, input logic [1:0] op, input int a, input int b,
                                 input bit glitch, input string tag);
        int res, flg, lat, bsy;
        int cycles, busy_cnt;
        refModel(w, op, a, b, res, flg, lat, bsy);
        @(negedge clk);
        sel4      = (w == 4);
        drv_start = 1'b1;
        drv_op    = op;
        drv_a     = 8'(a);
        drv_b     = 8'(b);
        @(posedge clk);
        #1;
        drv_start = 1'b0;
        drv_op    = 2'($urandom);
        drv_a     = 8'($urandom);
        drv_b     = 8'($urandom);
        cycles    = 0;
        busy_cnt  = 0;
        for (int i = 0; i < 40; i++) begin
            cycles++;
            if (obs_done) break;
            if (obs_busy) busy_cnt++;
            drv_start = (glitch && cycles == 3);
            @(posedge clk);
            #1;
        end
        drv_start = 1'b0;
        checkOutput({tag, ".latency"}, 32'(cycles), 32'(lat));
        checkOutput({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(bsy));
        checkOutput({tag, ".result"}, {16'h0, obs_result}, 32'(res));
        checkOutput({tag, ".flag"}, {31'h0, obs_flag}, 32'(flg));
        @(posedge clk);
        #1;
        checkOutput({tag, ".done_pulse"}, {31'h0, obs_done}, 32'd0);
        checkOutput({tag, ".result_hold"}, {16'h0, obs_result}, 32'(res));
    endtask

    initial begin
        int done_cnt;
        int ra, rb;
        logic [1:0] rop;
        checks    = 0;
        failures  = 0;
        sel4      = 1'b0;
        drv_start = 1'b0;
        drv_op    = OP_ADD;
        drv_a     = '0;
        drv_b     = '0;
        rst       = 1'b1;

        $display("[TB] reset values");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.busy",   {31'h0, bus8.busy}, 32'd0);
        checkOutput("reset.done",   {31'h0, bus8.done}, 32'd0);
        checkOutput("reset.result", {16'h0, bus8.result}, 32'd0);
        checkOutput("reset.flag",   {31'h0, bus8.flag}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed add/sub/mul/div");
        applyStimulus(8, OP_ADD, 200, 100, 1'b0, "add_200_100");
        applyStimulus(8, OP_ADD, 3,   4,   1'b0, "add_3_4");
        applyStimulus(8, OP_SUB, 5,   9,   1'b0, "sub_5_9");
        applyStimulus(8, OP_SUB, 9,   5,   1'b0, "sub_9_5");
        applyStimulus(8, OP_MUL, 255, 255, 1'b0, "mul_255_255");
        applyStimulus(8, OP_MUL, 12,  10,  1'b0, "mul_12_10");
        applyStimulus(8, OP_DIV, 200, 7,   1'b0, "div_200_7");
        applyStimulus(8, OP_DIV, 77,  0,   1'b0, "div_77_0");
        applyStimulus(8, OP_SUB, 0,   255, 1'b0, "sub_0_255");
        applyStimulus(8, OP_DIV, 255, 1,   1'b0, "div_255_1");

        $display("[TB] start pulsed during mul is ignored");
        applyStimulus(8, OP_MUL, 255, 255, 1'b1, "mul_glitch");

        $display("[TB] back-to-back with start held");
        @(negedge clk);
        sel4      = 1'b0;
        drv_start = 1'b1;
        drv_op    = OP_ADD;
        drv_a     = 8'd3;
        drv_b     = 8'd4;
        @(posedge clk);
        #1;
        checkOutput("b2b.first_done",   {31'h0, obs_done}, 32'd1);
        checkOutput("b2b.first_result", {16'h0, obs_result}, 32'd7);
        drv_op = OP_SUB;
        drv_a  = 8'd9;
        drv_b  = 8'd5;
        @(posedge clk);
        #1;
        drv_start = 1'b0;
        checkOutput("b2b.second_done",   {31'h0, obs_done}, 32'd1);
        checkOutput("b2b.second_result", {16'h0, obs_result}, 32'd4);
        checkOutput("b2b.second_flag",   {31'h0, obs_flag}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("b2b.idle_done", {31'h0, obs_done}, 32'd0);

        $display("[TB] reset during div");
        @(negedge clk);
        drv_start = 1'b1;
        drv_op    = OP_DIV;
        drv_a     = 8'd200;
        drv_b     = 8'd7;
        @(posedge clk);
        #1;
        drv_start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("rst_mid.busy_before", {31'h0, obs_busy}, 32'd1);
        checkOutput("rst_mid.result_before", {16'h0, obs_result}, 32'd4);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid.busy",   {31'h0, obs_busy}, 32'd0);
        checkOutput("rst_mid.done",   {31'h0, obs_done}, 32'd0);
        checkOutput("rst_mid.result", {16'h0, obs_result}, 32'd0);
        checkOutput("rst_mid.flag",   {31'h0, obs_flag}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (obs_done) done_cnt++;
        end
        checkOutput("rst_mid.no_done", 32'(done_cnt), 32'd0);
        applyStimulus(8, OP_ADD, 17, 25, 1'b0, "add_after_rst");

        $display("[TB] W=4 instance");
        applyStimulus(4, OP_MUL, 15, 15, 1'b0, "w4_mul_15_15");
        applyStimulus(4, OP_DIV, 13, 3,  1'b0, "w4_div_13_3");
        applyStimulus(4, OP_ADD, 9,  8,  1'b0, "w4_add_9_8");

        $display("[TB] randomized operations");
        for (int n = 0; n < 24; n++) begin
            rop = 2'($urandom);
            ra  = int'($urandom_range(0, 255));
            rb  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 255));
            applyStimulus(8, rop, ra, rb, 1'b0, "rand_w8");
        end
        for (int n = 0; n < 8; n++) begin
            rop = 2'($urandom);
            ra  = int'($urandom_range(0, 15));
            rb  = int'($urandom_range(0, 15));
            applyStimulus(4, rop, ra, rb, 1'b0, "rand_w4");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
